// File: rtl/stack_rpn_ctrl_if.sv
// Bus bundles around the RPN sequencer: the command side (switch/button logic to sequencer)
// and the stack side (sequencer to the LIFO). The sequencer is slave on cmd, master on stk.

interface rpn_cmd_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_operand;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             err;
    logic [3:0]       depth;

    modport master (
        output cmd_valid, cmd_op, cmd_operand,
        input  cmd_ready, result, result_valid, err, depth
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_operand,
        output cmd_ready, result, result_valid, err, depth
    );
endinterface

interface rpn_stk_if #(
    parameter int WIDTH = 4
);
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_din;
    logic [WIDTH-1:0] stk_dout;
    logic             stk_full;
    logic             stk_empty;

    modport master (
        output stk_push, stk_pop, stk_din,
        input  stk_dout, stk_full, stk_empty
    );

    modport slave (
        input  stk_push, stk_pop, stk_din,
        output stk_dout, stk_full, stk_empty
    );
endinterface

// File: rtl/stack_rpn_ctrl.sv
// Reverse-Polish command sequencer driving the push/pop side of a DEPTH x WIDTH LIFO.
// Tracks its own depth, rejects over/underflowing commands and pulses each result once.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a command; legality checked at the accept edge
// PUSHL  | push the captured literal
// POPA   | pop top entry (operand A / DUP / DROP source)
// POPB   | pop second entry; A captured from stack output
// CAPA   | capture popped value for DUP / DROP
// EXEC   | capture B, compute res = f(B, A)
// PUSHA  | first push of a DUP (copy of A)
// PUSHR  | push res
// DONE   | one-cycle result_valid with result
// ERR    | one-cycle err pulse, nothing else changes

module stack_rpn_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input logic       clk,
    input logic       rst,
    rpn_cmd_if.slave  cmd,
    rpn_stk_if.master stk
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_DUP  = 3'd6,
        OP_DROP = 3'd7
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSHL,
        S_POPA,
        S_POPB,
        S_CAPA,
        S_EXEC,
        S_PUSHA,
        S_PUSHR,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       depth_q, depth_d;
    logic             cmd_legal;
    logic             op_is_binary;

    // B is the deeper operand, so SUB is B - A; carries are dropped by the width.
    function automatic logic [WIDTH-1:0] alu(input op_e op,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = b + a;
            OP_SUB:  r = b - a;
            OP_AND:  r = b & a;
            OP_OR:   r = b | a;
            OP_XOR:  r = b ^ a;
            default: r = a;
        endcase
        return r;
    endfunction

    always_comb begin
        cmd_legal = 1'b0;
        case (op_e'(cmd.cmd_op))
            OP_PUSH: cmd_legal = (depth_q < DEPTH_C);
            OP_DUP:  cmd_legal = (depth_q >= 4'd1) && (depth_q <= DEPTH_C - 4'd1);
            OP_DROP: cmd_legal = (depth_q >= 4'd1);
            default: cmd_legal = (depth_q >= 4'd2);
        endcase
    end

    assign op_is_binary = (op_q != OP_PUSH) && (op_q != OP_DUP) && (op_q != OP_DROP);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        a_d       = a_q;
        res_d     = res_q;
        depth_d   = depth_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d      = op_e'(cmd.cmd_op);
                    operand_d = cmd.cmd_operand;
                    if (!cmd_legal)
                        state_d = S_ERR;
                    else if (op_e'(cmd.cmd_op) == OP_PUSH)
                        state_d = S_PUSHL;
                    else
                        state_d = S_POPA;
                end
            end
            S_PUSHL: begin
                res_d   = operand_q;
                depth_d = depth_q + 4'd1;
                state_d = S_DONE;
            end
            S_POPA: begin
                depth_d = depth_q - 4'd1;
                state_d = op_is_binary ? S_POPB : S_CAPA;
            end
            S_POPB: begin
                depth_d = depth_q - 4'd1;
                a_d     = stk.stk_dout;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = alu(op_q, stk.stk_dout, a_q);
                state_d = S_PUSHR;
            end
            S_CAPA: begin
                a_d     = stk.stk_dout;
                res_d   = stk.stk_dout;
                state_d = (op_q == OP_DUP) ? S_PUSHA : S_DONE;
            end
            S_PUSHA: begin
                depth_d = depth_q + 4'd1;
                state_d = S_PUSHR;
            end
            S_PUSHR: begin
                depth_d = depth_q + 4'd1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE)
            result_d = res_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_PUSH;
            operand_q <= '0;
            a_q       <= '0;
            res_q     <= '0;
            result_q  <= '0;
            depth_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            a_q       <= a_d;
            res_q     <= res_d;
            result_q  <= result_d;
            depth_q   <= depth_d;
        end
    end

    // Stack strobes and data depend only on registered state.
    always_comb begin
        stk.stk_push = 1'b0;
        stk.stk_pop  = 1'b0;
        stk.stk_din  = '0;
        case (state_q)
            S_PUSHL: begin
                stk.stk_push = 1'b1;
                stk.stk_din  = operand_q;
            end
            S_PUSHA: begin
                stk.stk_push = 1'b1;
                stk.stk_din  = a_q;
            end
            S_PUSHR: begin
                stk.stk_push = 1'b1;
                stk.stk_din  = res_q;
            end
            S_POPA, S_POPB: stk.stk_pop = 1'b1;
            default: ;
        endcase
    end

    assign cmd.cmd_ready    = (state_q == S_IDLE);
    assign cmd.result       = result_q;
    assign cmd.result_valid = (state_q == S_DONE);
    assign cmd.err          = (state_q == S_ERR);
    assign cmd.depth        = depth_q;

    // The stack flags are not used for control; they only cross-check the local depth count.
    a_flags_track_depth: assert property (@(posedge clk) disable iff (rst)
        (state_q != S_IDLE) ||
        ((stk.stk_full == (depth_q == DEPTH_C)) && (stk.stk_empty == (depth_q == 4'd0))));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(stk.stk_push && stk.stk_full));

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(stk.stk_pop && stk.stk_empty));

endmodule
